// File: rtl/lw_sha_pkg.sv
// Shared types and constants for the lightweight SHA-2 message schedule.
// Rotation/shift amounts cover both the 32-bit and 64-bit schedule variants.
package lw_sha_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_EXPAND = 2'd2
  } sched_state_e;

  localparam int unsigned BUF_DEPTH  = 16;
  localparam int unsigned ROUNDS_256 = 64;
  localparam int unsigned ROUNDS_512 = 80;

  localparam int unsigned S0_32_R1 = 7;
  localparam int unsigned S0_32_R2 = 18;
  localparam int unsigned S0_32_SH = 3;
  localparam int unsigned S1_32_R1 = 17;
  localparam int unsigned S1_32_R2 = 19;
  localparam int unsigned S1_32_SH = 10;

  localparam int unsigned S0_64_R1 = 1;
  localparam int unsigned S0_64_R2 = 8;
  localparam int unsigned S0_64_SH = 7;
  localparam int unsigned S1_64_R1 = 19;
  localparam int unsigned S1_64_R2 = 61;
  localparam int unsigned S1_64_SH = 6;

  // width selects a 32-bit rotate on the low half (upper half returned as zero) or a full 64-bit rotate
  function automatic logic [63:0] right_rotate(input logic [63:0] x,
                                               input int unsigned amt,
                                               input int unsigned width);
    logic [31:0] lo;
    lo = x[31:0];
    if (width == 32)
      right_rotate = {32'h0, (lo >> amt) | (lo << (32 - amt))};
    else
      right_rotate = (x >> amt) | (x << (64 - amt));
  endfunction

endpackage

// File: rtl/lw_sha_sched_sigma.sv
// Combinational small-sigma functions s0/s1 for the message schedule.
// mode 0 selects the SHA-224/256 variant, mode 1 the SHA-384/512 variant.
module lw_sha_sched_sigma
  import lw_sha_pkg::*;
#(
  parameter int unsigned WORD_W = 64
) (
  input  logic              mode,
  input  logic [WORD_W-1:0] x_s0,
  input  logic [WORD_W-1:0] x_s1,
  output logic [WORD_W-1:0] s0,
  output logic [WORD_W-1:0] s1
);

  logic [63:0] x0;
  logic [63:0] x1;
  logic [63:0] s0_32;
  logic [63:0] s1_32;
  logic [63:0] s0_64;
  logic [63:0] s1_64;
  logic [63:0] s0_full;
  logic [63:0] s1_full;

  always_comb begin
    x0 = '0;
    x1 = '0;
    x0[WORD_W-1:0] = x_s0;
    x1[WORD_W-1:0] = x_s1;
  end

  always_comb begin
    s0_32 = right_rotate(x0, S0_32_R1, 32) ^ right_rotate(x0, S0_32_R2, 32)
          ^ {32'h0, x0[31:0] >> S0_32_SH};
    s1_32 = right_rotate(x1, S1_32_R1, 32) ^ right_rotate(x1, S1_32_R2, 32)
          ^ {32'h0, x1[31:0] >> S1_32_SH};
    s0_64 = right_rotate(x0, S0_64_R1, 64) ^ right_rotate(x0, S0_64_R2, 64)
          ^ (x0 >> S0_64_SH);
    s1_64 = right_rotate(x1, S1_64_R1, 64) ^ right_rotate(x1, S1_64_R2, 64)
          ^ (x1 >> S1_64_SH);
  end

  always_comb begin
    s0_full = s0_32;
    s1_full = s1_32;
    if (mode && WORD_W == 64) begin
      s0_full = s0_64;
      s1_full = s1_64;
    end
  end

  assign s0 = s0_full[WORD_W-1:0];
  assign s1 = s1_full[WORD_W-1:0];

endmodule

// File: rtl/lw_sha_msg_schedule.sv
// SHA-2 message schedule: loads M0..M15 into a 16-entry circular buffer, then
// streams W_0..W_63 (mode 0) or W_0..W_79 (mode 1) with ready/valid backpressure.
module lw_sha_msg_schedule
  import lw_sha_pkg::*;
#(
  parameter int unsigned WORD_W = 64,
  parameter int unsigned RND_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_word,
  output logic [RND_W-1:0]  out_round,
  output logic              busy,
  output logic              done
);

  sched_state_e      state;
  sched_state_e      state_next;
  logic [3:0]        cnt;
  logic [RND_W-1:0]  t;
  logic [WORD_W-1:0] sched_buf [BUF_DEPTH];
  logic              mode_q;
  logic              done_q;

  logic              start_fire;
  logic              load_fire;
  logic              out_fire;
  logic              last_round;

  logic [3:0]        ti;
  logic [WORD_W-1:0] word_mask;
  logic [WORD_W-1:0] tap2;
  logic [WORD_W-1:0] tap7;
  logic [WORD_W-1:0] tap15;
  logic [WORD_W-1:0] tap16;
  logic [WORD_W-1:0] s0;
  logic [WORD_W-1:0] s1;
  logic [WORD_W-1:0] w_new;
  logic [WORD_W-1:0] w_cur;

  assign last_round = mode_q ? (t == RND_W'(ROUNDS_512 - 1))
                             : (t == RND_W'(ROUNDS_256 - 1));

  always_comb begin
    state_next = state;
    start_fire = 1'b0;
    load_fire  = 1'b0;
    out_fire   = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        start_fire = start & ~abort;
        if (start_fire) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        in_ready  = 1'b1;
        load_fire = in_valid & ~abort;
        if (load_fire && cnt == 4'd15) state_next = ST_EXPAND;
      end
      ST_EXPAND: begin
        out_valid = 1'b1;
        out_fire  = out_ready & ~abort;
        if (out_fire && last_round) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    // abort wins over any handshake presented in the same cycle
    if (abort) state_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    word_mask = '1;
    if (!mode_q) word_mask = WORD_W'(32'hFFFF_FFFF);
  end

  // Taps W[t-2], W[t-7], W[t-15], W[t-16] live at (t+14), (t+9), (t+1), t mod 16
  assign ti    = t[3:0];
  assign tap2  = sched_buf[ti + 4'd14];
  assign tap7  = sched_buf[ti + 4'd9];
  assign tap15 = sched_buf[ti + 4'd1];
  assign tap16 = sched_buf[ti];

  lw_sha_sched_sigma #(
    .WORD_W (WORD_W)
  ) u_sigma (
    .mode (mode_q),
    .x_s0 (tap15),
    .x_s1 (tap2),
    .s0   (s0),
    .s1   (s1)
  );

  assign w_new = (s1 + tap7 + s0 + tap16) & word_mask;
  assign w_cur = (t < RND_W'(BUF_DEPTH)) ? tap16 : w_new;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      t      <= '0;
      mode_q <= 1'b0;
      done_q <= 1'b0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) sched_buf[i] <= '0;
    end else begin
      done_q <= out_fire & last_round;
      if (start_fire) begin
        mode_q <= (WORD_W == 64) ? mode : 1'b0;
        cnt    <= '0;
        t      <= '0;
      end
      if (load_fire) begin
        sched_buf[cnt] <= in_word & word_mask;
        cnt            <= cnt + 4'd1;
      end
      if (out_fire) begin
        if (t >= RND_W'(BUF_DEPTH)) sched_buf[ti] <= w_new;
        t <= last_round ? '0 : t + RND_W'(1);
      end
      if (abort) begin
        cnt <= '0;
        t   <= '0;
      end
    end
  end

  assign out_word  = (state == ST_EXPAND) ? w_cur : '0;
  assign out_round = (state == ST_EXPAND) ? t : '0;
  assign busy      = (state != ST_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_lw_sha_msg_schedule.sv
// Self-checking bench for lw_sha_msg_schedule: known-answer vectors, random
// blocks against a reference schedule model, stalls, abort and mid-block reset.
module tb_lw_sha_msg_schedule;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        mode;
  logic        abort;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_word;
  logic [6:0]  out_round;
  logic        busy;
  logic        done;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [63:0] msg   [16];
  logic [63:0] exp_w [80];
  logic [63:0] got_w [80];
  int          n_got;

  typedef struct {
    logic        md;
    logic [63:0] m0;
    logic [63:0] m15;
    logic [63:0] w16;
    logic [63:0] w17;
    int          rounds;
  } vec_t;

  vec_t vecs [3];

  lw_sha_msg_schedule #(
    .WORD_W (64),
    .RND_W  (7)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mode      (mode),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_round (out_round),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Reference schedule straight from the SHA-2 recurrence
  task automatic compute_model(input logic md);
    logic [31:0] a, b, c, d, r;
    for (int i = 0; i < 16; i++)
      exp_w[i] = md ? msg[i] : {32'h0, msg[i][31:0]};
    for (int i = 16; i < 80; i++) begin
      if (md) begin
        exp_w[i] = (rotr64(exp_w[i-2], 19) ^ rotr64(exp_w[i-2], 61) ^ (exp_w[i-2] >> 6))
                 + exp_w[i-7]
                 + (rotr64(exp_w[i-15], 1) ^ rotr64(exp_w[i-15], 8) ^ (exp_w[i-15] >> 7))
                 + exp_w[i-16];
      end else begin
        a = exp_w[i-2][31:0];
        b = exp_w[i-7][31:0];
        c = exp_w[i-15][31:0];
        d = exp_w[i-16][31:0];
        r = (rotr32(a, 17) ^ rotr32(a, 19) ^ (a >> 10)) + b
          + (rotr32(c, 7) ^ rotr32(c, 18) ^ (c >> 3)) + d;
        exp_w[i] = {32'h0, r};
      end
    end
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic run_block(input logic md, input bit rstall, input int abort_at, input int start_at);
    int          n;
    int          i;
    int          cyc;
    bit          hs;
    bit          stalled;
    logic [63:0] prev;
    n = md ? 80 : 64;
    compute_model(md);
    start = 1'b1;
    mode  = md;
    @(posedge clk); #1;
    start = 1'b0;
    mode  = 1'($urandom);
    check("busy_after_start", busy, 1);
    i = 0;
    cyc = 0;
    while (i < 16 && cyc < 200) begin
      in_valid = ($urandom % 4) != 0;
      in_word  = in_valid ? msg[i] : {$urandom, $urandom};
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) i++;
      cyc++;
    end
    in_valid = 1'b0;
    if (i < 16) check("load_timeout", 64'(i), 64'd16);
    check("first_word_latency", out_valid, 1);
    n_got = 0;
    stalled = 0;
    prev = '0;
    cyc = 0;
    while (n_got < n && cyc < 2000) begin
      if (n_got == abort_at) begin
        abort = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        out_ready = 1'b0;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(posedge clk); #1;
        check("abort_no_done", done, 0);
        return;
      end
      start = (n_got == start_at);
      mode  = 1'($urandom);
      if (!out_valid) begin
        check("out_valid_dropped", out_valid, 1);
        break;
      end
      if (stalled) check("stall_hold", out_word, prev);
      check("word", out_word, exp_w[n_got]);
      check("round", 64'(out_round), 64'(n_got));
      out_ready = rstall ? 1'($urandom) : 1'b1;
      prev = out_word;
      stalled = !out_ready;
      hs = out_ready;
      @(posedge clk); #1;
      if (hs) begin
        got_w[n_got] = prev;
        n_got++;
      end
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b0;
    check("round_count", 64'(n_got), 64'(n));
    check("done_pulse", done, 1);
    check("busy_at_done", busy, 0);
    check("valid_at_done", out_valid, 0);
  endtask

  task automatic set_abc(input logic md);
    for (int k = 0; k < 16; k++) msg[k] = '0;
    msg[0]  = md ? 64'h6162638000000000 : 64'h0000000061626380;
    msg[15] = 64'h18;
  endtask

  task automatic set_random();
    for (int k = 0; k < 16; k++) msg[k] = {$urandom, $urandom};
  endtask

  initial begin
    vecs[0] = '{md: 1'b0, m0: 64'h0000000061626380, m15: 64'h18,
                w16: 64'h0000000061626380, w17: 64'h00000000000F0000, rounds: 64};
    vecs[1] = '{md: 1'b1, m0: 64'h6162638000000000, m15: 64'h18,
                w16: 64'h6162638000000000, w17: 64'h00030000000000C0, rounds: 80};
    vecs[2] = '{md: 1'b0, m0: 64'hDEADBEEF61626380, m15: 64'hCAFEF00D00000018,
                w16: 64'h0000000061626380, w17: 64'h00000000000F0000, rounds: 64};

    rst_n = 1'b0; start = 1'b0; mode = 1'b0; abort = 1'b0;
    in_valid = 1'b0; in_word = '0; out_ready = 1'b0;
    #3;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_word", out_word, 0);
    check("rst_out_round", 64'(out_round), 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    // Known answers; consecutive calls also start in the done cycle
    for (int v = 0; v < 3; v++) begin
      for (int k = 0; k < 16; k++) msg[k] = '0;
      msg[0]  = vecs[v].m0;
      msg[15] = vecs[v].m15;
      run_block(vecs[v].md, 1'b0, -1, -1);
      check("vec_w16", got_w[16], vecs[v].w16);
      check("vec_w17", got_w[17], vecs[v].w17);
      check("vec_rounds", 64'(n_got), 64'(vecs[v].rounds));
    end
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);

    set_abc(1'b0);
    run_block(1'b0, 1'b1, -1, -1);
    set_abc(1'b1);
    run_block(1'b1, 1'b1, -1, -1);

    set_random();
    run_block(1'b1, 1'b0, -1, 20);
    check("start_in_expand_w20", got_w[20], exp_w[20]);

    set_abc(1'b0);
    run_block(1'b0, 1'b0, 30, -1);
    run_block(1'b0, 1'b0, -1, -1);
    check("post_abort_w16", got_w[16], 64'h0000000061626380);
    check("post_abort_w17", got_w[17], 64'h00000000000F0000);

    // Reset while loading word 7
    set_random();
    start = 1'b1; mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      in_valid = 1'b1;
      in_word = msg[k];
      @(posedge clk); #1;
    end
    in_word = msg[7];
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_word", out_word, 0);
    check("midrst_out_round", 64'(out_round), 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    in_valid = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", busy, 0);
    set_random();
    run_block(1'b1, 1'b1, -1, -1);

    for (int r = 0; r < 4; r++) begin
      set_random();
      run_block(1'($urandom), 1'($urandom), -1, -1);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/lw_sha_msg_schedule.md
LW_SHA_MSG_SCHEDULE -- requirements
Module: lw_sha_msg_schedule

Interface
REQ-001 SHALL have parameter WORD_W, default 64, meaning datapath word width; only 32 or 64 are legal.
REQ-002 SHALL have parameter RND_W, default 7, meaning round-index width.
REQ-003 SHALL have port clk  input  1  system clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  begin a new message block; honoured only in IDLE.
REQ-006 SHALL have port mode  input  1  0 = SHA-224/256 (64 rounds), 1 = SHA-384/512 (80 rounds); sampled on accepted start; forced 0 when WORD_W=32.
REQ-007 SHALL have port abort  input  1  synchronous cancel of the current block.
REQ-008 SHALL have port in_valid  input  1  in_word valid.
REQ-009 SHALL have port in_ready  output  1  block accepts a message word.
REQ-010 SHALL have port in_word  input  WORD_W  message word, M0 first; only low 32 bits used in mode 0.
REQ-011 SHALL have port out_valid  output  1  out_word valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts out_word.
REQ-013 SHALL have port out_word  output  WORD_W  schedule word W_t; upper 32 bits zero in mode 0.
REQ-014 SHALL have port out_round  output  RND_W  index t of out_word.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse after the last W_t is accepted.

Function
REQ-017 SHALL implement FSM IDLE -> LOAD (accepted start) -> EXPAND (16th word accepted) -> IDLE (last round accepted).
REQ-018 SHALL hold a 16-entry WORD_W circular buffer and a 4-bit load counter in LOAD.
REQ-019 SHALL assert in_ready only in LOAD; each in_valid&in_ready writes buf[cnt] and increments cnt.
REQ-020 SHALL assert out_valid in EXPAND from the cycle after the 16th load handshake; latency from last load to first W_t is 1 cycle.
REQ-021 SHALL drive out_word = buf[t] for t<16, and W_t = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16] for t>=16, with indices taken mod 16 from buf.
REQ-022 SHALL, on each out handshake with t>=16, write W_t into buf[t mod 16] and increment t.
REQ-023 SHALL use, in mode 0, s0 = ROTR7^ROTR18^SHR3 and s1 = ROTR17^ROTR19^SHR10 on 32 bits, with addition mod 2^32.
REQ-024 SHALL use, in mode 1, s0 = ROTR1^ROTR8^SHR7 and s1 = ROTR19^ROTR61^SHR6 on 64 bits, with addition mod 2^64.
REQ-025 SHALL hold out_word, out_round and out_valid stable while out_valid&!out_ready (backpressure).
REQ-026 SHALL pulse done in the cycle after the t=63 (mode 0) or t=79 (mode 1) handshake, returning to IDLE in that same cycle.
REQ-027 SHALL ignore start outside IDLE; mode SHALL NOT change mid-block.
REQ-028 SHALL, on abort in any state, enter IDLE next cycle, deassert in_ready/out_valid, and not pulse done; abort overrides a simultaneous handshake, which is dropped.
REQ-029 SHALL accept start in the cycle following done, allowing back-to-back blocks with no other idle gap.

Reset
REQ-030 SHALL on rst_n low asynchronously force state IDLE, cnt=0, t=0, buf all zero, and in_ready, out_valid, out_word, out_round, busy, done all 0.
REQ-031 SHALL exit reset on the first rising clk after rst_n deasserts; reset mid-block discards the block.

Structure
REQ-032 SHALL place the state enum, round-count constants (64/80), and rotation/shift amounts in lw_sha_pkg, reusing its right_rotate function.
REQ-033 SHALL instantiate one combinational sub-module lw_sha_sched_sigma computing mode-selectable s0/s1.

Verification
REQ-034 SHALL cover SHA-256 "abc": M0=0x61626380, M15=0x18, others 0 -> W16=0x61626380, W17=0x000F0000, 64 words then done.
REQ-035 SHALL cover SHA-512 "abc": M0=0x6162638000000000, M15=0x18 -> W16=0x6162638000000000, W17=0x00030000000000C0, 80 words then done.
REQ-036 SHALL cover random out_ready toggling -> word sequence identical to the no-stall run, with out_word stable while stalled.
REQ-037 SHALL cover abort at t=30 then a new "abc" block -> no done for the aborted block; second block matches REQ-034.
REQ-038 SHALL cover rst_n low at load word 7 -> all outputs 0 immediately; a subsequent full block is correct.
REQ-039 SHALL cover start asserted during EXPAND -> ignored; back-to-back start in the cycle after done -> accepted.
